scaled_scanout: RTL and testbench
=================================

# scaled_scanout

Parametrised letterboxing scanout engine for the HDMI pixel domain: maps screen coordinates to a FRAME_WIDTH×FRAME_HEIGHT indexed-colour frame with independent integer X/Y scaling, palette lookup and border fill. It replaces per-pixel random framebuffer reads with a ping-pong line buffer: each source row is fetched once, one screen line ahead, then replayed SCALE_Y times. It sits between the framebuffer/palette RAMs and the HDMI encoder and also drives the hblank/vblank flags used by the SPI side.

## Interface
- FRAME_WIDTH, 320, source pixels per row
- FRAME_HEIGHT, 240, source rows
- SCALE_X, 3, horizontal integer scale (≥1)
- SCALE_Y, 3, vertical integer scale (≥1)
- PIXEL_BITS, 8, palette index width
- RGB_BITS, 24, palette entry / output width
- ADDR_BITS, 17, framebuffer address width (≥ clog2(FRAME_WIDTH*FRAME_HEIGHT))
- clk_pixel  in  1  sole clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- cx, cy  in  12 each  current screen coordinate from the HDMI timing generator
- screen_width, screen_height  in  12 each  active area; static while out of reset
- fb_rd  out  1  framebuffer read strobe
- fb_addr  out  ADDR_BITS  framebuffer read address
- fb_data  in  PIXEL_BITS  read data, valid exactly 1 cycle after fb_rd
- palette_addr  out  PIXEL_BITS  palette read address
- palette_data  in  RGB_BITS  palette data, valid 1 cycle after palette_addr
- screen_rgb_out  out  RGB_BITS  pixel to encoder
- hblank, vblank  out  1 each  outside frame window horizontally / vertically (or in screen blanking)
- underrun  out  1  sticky: a row swap occurred before its fetch completed

## Operation
- border_left = (screen_width − FRAME_WIDTH*SCALE_X)/2, border_top = (screen_height − FRAME_HEIGHT*SCALE_Y)/2, 12-bit unsigned, truncating; registered once after reset.
- No dividers/multipliers: source x via sub-counter 0..SCALE_X−1 plus x counter, reset when cx == border_left; source row via sub-counter 0..SCALE_Y−1 plus row counter, reset at cx==0, cy==border_top, advanced at each cx==0 inside the window. Row base address accumulates += FRAME_WIDTH.
- Fetch FSM: IDLE → FETCH → DRAIN → IDLE.
  - Trigger at cx==0 when the next screen line starts a new source row: cy == border_top−1 (row 0), or inside window with y_sub == SCALE_Y−1 and row < FRAME_HEIGHT−1.
  - FETCH: fb_rd=1 for FRAME_WIDTH consecutive cycles, fb_addr = base, base+1, …; data written to back buffer at index x one cycle later.
  - DRAIN: one cycle capturing the final word; then back buffer marked ready.
- Swap: at cx==0 of the first screen line of a new source row the buffers exchange. If FSM not IDLE at swap, underrun←1 (held until rst); fetch continues into the now-front buffer.
- Output select: outside active area → 0; inside active but outside frame window → border fill (see Configuration); inside window → palette_data.
- hblank = cx outside [border_left, border_left+FRAME_WIDTH*SCALE_X) or cx ≥ screen_width; vblank likewise for cy.

## Timing
- Fixed 3-cycle latency: cx/cy sampled at cycle t → screen_rgb_out, hblank, vblank at t+3 (line-buffer read t+1, palette_data t+2, output register t+3). All three flags/data aligned.
- Fetch of one row: FRAME_WIDTH+1 cycles from trigger; requires total screen line length ≥ FRAME_WIDTH+2.
- Reset values: screen_rgb_out=0, fb_rd=0, fb_addr=0, palette_addr=0, hblank=1, vblank=1, underrun=0, FSM IDLE, both buffers not-ready. Reset mid-fetch aborts immediately; next trigger restarts from row 0 behaviour.
- screen_width < FRAME_WIDTH*SCALE_X (negative border): unsupported; window never entered, output is fill only.

## Configuration
- SCANOUT_BORDER_PATTERN_EN defined: border fill = {cx[7:0], cy[7:0], (cx+cy)[7:0]} zero-extended/truncated to RGB_BITS, using the cx/cy of that pixel.
- Undefined: border fill = 0.

## Test plan
- Params 8×4, scale 2×2, screen 32×16 (border_left=8, border_top=4): fb[i]=i, palette[i]={i,i,i} → pixel at (cx=10,cy=6) appears 3 cycles later as 0x090909 (row 1, x 1).
- Same config: fb_rd pulses exactly 8 cycles at cx=0 of cy=3, addresses 0..7; at cy=5 addresses 8..15; no fetch after row 3.
- Border with macro defined: (cx=2,cy=1) → 0x020103; without macro → 0x000000; cx≥32 → 0, hblank=1.
- Screen line length 9 cycles (<FRAME_WIDTH+2) → underrun=1 at first swap, stays 1 until rst.
- Assert rst during FETCH at fb_addr=5 → fb_rd=0 next edge, all outputs at reset values, underrun=0.

Source files
------------

// File: rtl/scaled_scanout.sv
// -----------------------------------------------------------------------------
// scaled_scanout
//   Letterboxing scanout engine for the HDMI pixel domain. Maps screen
//   coordinates onto a FRAME_WIDTH x FRAME_HEIGHT indexed-colour frame with
//   integer X/Y scaling, looks the index up in the palette and fills the
//   border around the frame. Each source row is fetched from the framebuffer
//   once, one screen line ahead, into a ping-pong line buffer and replayed
//   SCALE_Y times.
//
//   Optional feature: define SCANOUT_BORDER_PATTERN_EN to fill the border
//   with {cx[7:0], cy[7:0], (cx+cy)[7:0]}; otherwise the border is black.
//
// Ports
//   clk_pixel       in   pixel clock, all logic on rising edge
//   rst             in   asynchronous active-high reset
//   cx, cy          in   current screen coordinate (12 bit each)
//   screen_width    in   active width, static while out of reset
//   screen_height   in   active height, static while out of reset
//   fb_rd           out  framebuffer read strobe
//   fb_addr         out  framebuffer read address
//   fb_data         in   framebuffer data, valid 1 cycle after fb_rd
//   palette_addr    out  palette read address
//   palette_data    in   palette entry, valid 1 cycle after palette_addr
//   screen_rgb_out  out  pixel to encoder (3 cycles after cx/cy)
//   hblank, vblank  out  outside frame window / screen, aligned with pixel
//   underrun        out  sticky: row swap happened before its fetch ended
// -----------------------------------------------------------------------------
module scaled_scanout #(
   parameter int FRAME_WIDTH  = 320,
   parameter int FRAME_HEIGHT = 240,
   parameter int SCALE_X      = 3,
   parameter int SCALE_Y      = 3,
   parameter int PIXEL_BITS   = 8,
   parameter int RGB_BITS     = 24,
   parameter int ADDR_BITS    = 17
) (
   input  logic                  clk_pixel,
   input  logic                  rst,
   input  logic [11:0]           cx,
   input  logic [11:0]           cy,
   input  logic [11:0]           screen_width,
   input  logic [11:0]           screen_height,
   output logic                  fb_rd,
   output logic [ADDR_BITS-1:0]  fb_addr,
   input  logic [PIXEL_BITS-1:0] fb_data,
   output logic [PIXEL_BITS-1:0] palette_addr,
   input  logic [RGB_BITS-1:0]   palette_data,
   output logic [RGB_BITS-1:0]   screen_rgb_out,
   output logic                  hblank,
   output logic                  vblank,
   output logic                  underrun
);

   localparam int XW  = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
   localparam int RW  = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
   localparam int SXW = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
   localparam int SYW = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;

   localparam logic [12:0]          WIN_W      = 13'(FRAME_WIDTH * SCALE_X);
   localparam logic [12:0]          WIN_H      = 13'(FRAME_HEIGHT * SCALE_Y);
   localparam logic [ADDR_BITS-1:0] ROW_STRIDE = ADDR_BITS'(FRAME_WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_DRAIN
   } fetch_state_e;

   typedef enum logic [1:0] {
      PX_BLANK,
      PX_BORDER,
      PX_FRAME
   } px_class_e;

   // ---------------------------------------------------------------------------
   // Border geometry, captured once after reset. x_neg/y_neg reset to 1 so
   // nothing is windowed or fetched until the geometry is valid.
   // ---------------------------------------------------------------------------
   logic        cfg_done_q;
   logic [11:0] border_left_q, border_left_d;
   logic [11:0] border_top_q,  border_top_d;
   logic        x_neg_q, x_neg_d;
   logic        y_neg_q, y_neg_d;
   logic [11:0] diff_w, diff_h;

   always_comb begin
      diff_w        = screen_width  - WIN_W[11:0];
      diff_h        = screen_height - WIN_H[11:0];
      border_left_d = {1'b0, diff_w[11:1]};
      border_top_d  = {1'b0, diff_h[11:1]};
      x_neg_d       = ({1'b0, screen_width}  < WIN_W);
      y_neg_d       = ({1'b0, screen_height} < WIN_H);
   end

   always_ff @(posedge clk_pixel or posedge rst) begin
      if (rst) begin
         cfg_done_q    <= 1'b0;
         border_left_q <= '0;
         border_top_q  <= '0;
         x_neg_q       <= 1'b1;
         y_neg_q       <= 1'b1;
      end else if (!cfg_done_q) begin
         cfg_done_q    <= 1'b1;
         border_left_q <= border_left_d;
         border_top_q  <= border_top_d;
         x_neg_q       <= x_neg_d;
         y_neg_q       <= y_neg_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Window decode for the current coordinate
   // ---------------------------------------------------------------------------
   logic [12:0] x_end, y_end;
   logic        hb_now, vb_now, win_now, active_now, line_start;

   always_comb begin
      x_end      = {1'b0, border_left_q} + WIN_W;
      y_end      = {1'b0, border_top_q}  + WIN_H;
      hb_now     = x_neg_q || (cx < border_left_q) || ({1'b0, cx} >= x_end) ||
                   (cx >= screen_width);
      vb_now     = y_neg_q || (cy < border_top_q)  || ({1'b0, cy} >= y_end) ||
                   (cy >= screen_height);
      win_now    = !hb_now && !vb_now;
      active_now = (cx < screen_width) && (cy < screen_height);
      line_start = (cx == 12'd0);
   end

   // ---------------------------------------------------------------------------
   // Source x: the registers hold the position of the pixel one past the last
   // sampled cx, so the current position is available combinationally and the
   // counter restarts on the same cycle cx hits border_left.
   // ---------------------------------------------------------------------------
   logic [SXW-1:0] x_sub_q, x_sub_d, cur_x_sub;
   logic [XW-1:0]  x_cnt_q, x_cnt_d, cur_x;

   always_comb begin
      if (cx == border_left_q) begin
         cur_x_sub = '0;
         cur_x     = '0;
      end else begin
         cur_x_sub = x_sub_q;
         cur_x     = x_cnt_q;
      end
      if (cur_x_sub == SXW'(SCALE_X - 1)) begin
         x_sub_d = '0;
         x_cnt_d = cur_x + XW'(1);
      end else begin
         x_sub_d = cur_x_sub + SXW'(1);
         x_cnt_d = cur_x;
      end
   end

   // ---------------------------------------------------------------------------
   // Source row tracking, evaluated at the start of every screen line. The _d
   // values describe the line that is starting now.
   // ---------------------------------------------------------------------------
   logic [SYW-1:0]       y_sub_q, y_sub_d;
   logic [RW-1:0]        row_q, row_d;
   logic [ADDR_BITS-1:0] base_q, base_d;
   logic                 swap;
   logic                 trig;
   logic [ADDR_BITS-1:0] trig_base;

   always_comb begin
      y_sub_d = y_sub_q;
      row_d   = row_q;
      base_d  = base_q;
      swap    = 1'b0;
      if (line_start && !y_neg_q) begin
         if (cy == border_top_q) begin
            y_sub_d = '0;
            row_d   = '0;
            base_d  = '0;
            swap    = 1'b1;
         end else if (!vb_now) begin
            if (y_sub_q == SYW'(SCALE_Y - 1)) begin
               y_sub_d = '0;
               row_d   = row_q + RW'(1);
               base_d  = base_q + ROW_STRIDE;
               swap    = 1'b1;
            end else begin
               y_sub_d = y_sub_q + SYW'(1);
            end
         end
      end
   end

   // Fetch trigger: the next screen line begins a new source row.
   always_comb begin
      trig      = 1'b0;
      trig_base = '0;
      if (line_start && !y_neg_q) begin
         if (cy == border_top_q - 12'd1) begin
            trig      = 1'b1;
            trig_base = '0;
         end else if (!vb_now && (y_sub_d == SYW'(SCALE_Y - 1)) &&
                      (row_d < RW'(FRAME_HEIGHT - 1))) begin
            trig      = 1'b1;
            trig_base = base_d + ROW_STRIDE;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Fetch FSM and ping-pong buffer bookkeeping
   // ---------------------------------------------------------------------------
   fetch_state_e         state_q, state_d;
   logic [ADDR_BITS-1:0] fa_q, fa_d;
   logic [XW-1:0]        fx_q, fx_d;
   logic                 fill_q, fill_d;
   logic                 front_q, front_d;
   logic [1:0]           ready_q, ready_d;
   logic                 clr_ready, set_ready;
   logic                 underrun_q, underrun_d;
   logic                 wr_en_q;
   logic [XW-1:0]        wr_idx_q;

   always_comb begin
      front_d    = swap ? ~front_q : front_q;
      underrun_d = underrun_q | (swap && (state_q != S_IDLE));
   end

   always_comb begin
      state_d   = state_q;
      fa_d      = fa_q;
      fx_d      = fx_q;
      fill_d    = fill_q;
      clr_ready = 1'b0;
      set_ready = 1'b0;
      fb_rd     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (trig) begin
               state_d   = S_FETCH;
               fa_d      = trig_base;
               fx_d      = '0;
               // A fetch launched on a swap line targets the post-swap back buffer.
               fill_d    = ~front_d;
               clr_ready = 1'b1;
            end
         end
         S_FETCH: begin
            fb_rd = 1'b1;
            if (fx_q == XW'(FRAME_WIDTH - 1)) begin
               state_d = S_DRAIN;
            end else begin
               fa_d = fa_q + ADDR_BITS'(1);
               fx_d = fx_q + XW'(1);
            end
         end
         S_DRAIN: begin
            set_ready = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ready_d = ready_q;
      if (clr_ready) ready_d[fill_d] = 1'b0;
      if (set_ready) ready_d[fill_q] = 1'b1;
   end

   assign fb_addr  = fa_q;
   assign underrun = underrun_q;

   // ---------------------------------------------------------------------------
   // Line buffer storage (no reset)
   // ---------------------------------------------------------------------------
   logic [PIXEL_BITS-1:0] line_buf_q [2][FRAME_WIDTH];
   logic [PIXEL_BITS-1:0] lb_rd_d;

   always_ff @(posedge clk_pixel) begin
      if (wr_en_q) line_buf_q[fill_q][wr_idx_q] <= fb_data;
   end

   always_comb begin
      lb_rd_d = '0;
      if (win_now && ready_q[front_d]) lb_rd_d = line_buf_q[front_d][cur_x];
   end

   // ---------------------------------------------------------------------------
   // Border fill
   // ---------------------------------------------------------------------------
   logic [RGB_BITS-1:0] fill_now;

`ifdef SCANOUT_BORDER_PATTERN_EN
   logic [7:0]  pat_sum;
   logic [23:0] pat_rgb;

   always_comb begin
      pat_sum  = cx[7:0] + cy[7:0];
      pat_rgb  = {cx[7:0], cy[7:0], pat_sum};
      fill_now = RGB_BITS'(pat_rgb);
   end
`else
   always_comb begin
      fill_now = '0;
   end
`endif

   px_class_e cls_now;

   always_comb begin
      if (win_now)         cls_now = PX_FRAME;
      else if (active_now) cls_now = PX_BORDER;
      else                 cls_now = PX_BLANK;
   end

   // ---------------------------------------------------------------------------
   // Pipeline: stage 1 line-buffer read, stage 2 palette read, stage 3 output
   // ---------------------------------------------------------------------------
   logic [PIXEL_BITS-1:0] pal_addr_q;
   px_class_e             cls1_q, cls2_q;
   logic [RGB_BITS-1:0]   fill1_q, fill2_q;
   logic                  hb1_q, hb2_q, vb1_q, vb2_q;
   logic [RGB_BITS-1:0]   rgb_q, rgb_d;
   logic                  hblank_q, vblank_q;

   always_comb begin
      case (cls2_q)
         PX_FRAME:  rgb_d = palette_data;
         PX_BORDER: rgb_d = fill2_q;
         default:   rgb_d = '0;
      endcase
   end

   always_ff @(posedge clk_pixel or posedge rst) begin
      if (rst) begin
         x_sub_q    <= '0;
         x_cnt_q    <= '0;
         y_sub_q    <= '0;
         row_q      <= '0;
         base_q     <= '0;
         state_q    <= S_IDLE;
         fa_q       <= '0;
         fx_q       <= '0;
         fill_q     <= 1'b0;
         front_q    <= 1'b0;
         ready_q    <= '0;
         underrun_q <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_idx_q   <= '0;
         pal_addr_q <= '0;
         cls1_q     <= PX_BLANK;
         cls2_q     <= PX_BLANK;
         fill1_q    <= '0;
         fill2_q    <= '0;
         hb1_q      <= 1'b1;
         hb2_q      <= 1'b1;
         vb1_q      <= 1'b1;
         vb2_q      <= 1'b1;
         rgb_q      <= '0;
         hblank_q   <= 1'b1;
         vblank_q   <= 1'b1;
      end else begin
         x_sub_q    <= x_sub_d;
         x_cnt_q    <= x_cnt_d;
         y_sub_q    <= y_sub_d;
         row_q      <= row_d;
         base_q     <= base_d;
         state_q    <= state_d;
         fa_q       <= fa_d;
         fx_q       <= fx_d;
         fill_q     <= fill_d;
         front_q    <= front_d;
         ready_q    <= ready_d;
         underrun_q <= underrun_d;
         wr_en_q    <= (state_q == S_FETCH);
         wr_idx_q   <= fx_q;
         pal_addr_q <= lb_rd_d;
         cls1_q     <= cls_now;
         cls2_q     <= cls1_q;
         fill1_q    <= fill_now;
         fill2_q    <= fill1_q;
         hb1_q      <= hb_now;
         hb2_q      <= hb1_q;
         vb1_q      <= vb_now;
         vb2_q      <= vb1_q;
         rgb_q      <= rgb_d;
         hblank_q   <= hb2_q;
         vblank_q   <= vb2_q;
      end
   end

   assign palette_addr   = pal_addr_q;
   assign screen_rgb_out = rgb_q;
   assign hblank         = hblank_q;
   assign vblank         = vblank_q;

endmodule

// File: tb/tb_scaled_scanout.sv
module tb_scaled_scanout;

   localparam int FW = 8;
   localparam int FH = 4;
   localparam int SX = 2;
   localparam int SY = 2;
   localparam int PB = 8;
   localparam int RB = 24;
   localparam int AB = 17;
   localparam int SW = 32;
   localparam int SH = 16;
   localparam int BL = (SW - FW * SX) / 2;
   localparam int BT = (SH - FH * SY) / 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [11:0]   cx, cy, sw, sh;
   logic          fb_rd;
   logic [AB-1:0] fb_addr;
   logic [PB-1:0] fb_data = '0;
   logic [PB-1:0] palette_addr;
   logic [RB-1:0] palette_data = '0;
   logic [RB-1:0] screen_rgb_out;
   logic          hblank, vblank, underrun;

   scaled_scanout #(
      .FRAME_WIDTH (FW),
      .FRAME_HEIGHT(FH),
      .SCALE_X     (SX),
      .SCALE_Y     (SY),
      .PIXEL_BITS  (PB),
      .RGB_BITS    (RB),
      .ADDR_BITS   (AB)
   ) dut (
      .clk_pixel     (clk),
      .rst           (rst),
      .cx            (cx),
      .cy            (cy),
      .screen_width  (sw),
      .screen_height (sh),
      .fb_rd         (fb_rd),
      .fb_addr       (fb_addr),
      .fb_data       (fb_data),
      .palette_addr  (palette_addr),
      .palette_data  (palette_data),
      .screen_rgb_out(screen_rgb_out),
      .hblank        (hblank),
      .vblank        (vblank),
      .underrun      (underrun)
   );

   // Framebuffer and palette RAMs, one-cycle read latency
   logic [PB-1:0] fb_mem [FW*FH];
   logic [RB-1:0] pal    [256];

   always @(posedge clk) begin
      if (fb_rd) fb_data <= fb_mem[int'(fb_addr) % (FW * FH)];
      palette_data <= pal[palette_addr];
   end

   typedef struct {
      int            x;
      int            y;
      logic [RB-1:0] rgb;
      logic          hb;
      logic          vb;
      bit            det;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   htot, vtot, ncx, ncy, pcx, pcy, frame;
   bit   prev_valid, ur_exp, pix_chk, det_frame;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [RB-1:0] fill_of(int x, int y);
`ifdef SCANOUT_BORDER_PATTERN_EN
      logic [7:0] a, b, c;
      a = 8'(x);
      b = 8'(y);
      c = 8'(x + y);
      return {a, b, c};
`else
      return '0;
`endif
   endfunction

   // Reference: letterbox geometry, integer scaling by division, palette lookup
   function automatic exp_t model(int x, int y);
      exp_t e;
      e.x   = x;
      e.y   = y;
      e.det = det_frame;
      e.hb  = !(x >= BL && x < BL + FW * SX && x < SW);
      e.vb  = !(y >= BT && y < BT + FH * SY && y < SH);
      if (!e.hb && !e.vb)
         e.rgb = pal[fb_mem[((y - BT) / SY) * FW + (x - BL) / SX]];
      else if (x < SW && y < SH)
         e.rgb = fill_of(x, y);
      else
         e.rgb = '0;
      return e;
   endfunction

   task automatic step();
      bit   rd_e;
      int   ad_e, r;
      exp_t e;
      @(posedge clk);
      #1;
      // Row r is fetched during the first FW cycles of screen line BT-1+r*SY
      rd_e = 1'b0;
      ad_e = 0;
      if (prev_valid && pcx < FW && pcy >= BT - 1 && ((pcy - (BT - 1)) % SY) == 0) begin
         r = (pcy - (BT - 1)) / SY;
         if (r < FH) begin
            rd_e = 1'b1;
            ad_e = r * FW + pcx;
         end
      end
      chk("fb_rd", fb_rd, rd_e);
      if (rd_e) chk("fb_addr", fb_addr, ad_e);
      if (prev_valid && pcx == 0 && pcy == BT && htot < FW + 2) ur_exp = 1'b1;
      chk("underrun", underrun, ur_exp);
      if (q.size() == 3) begin
         e = q.pop_front();
         if (pix_chk) begin
            chk("rgb", screen_rgb_out, e.rgb);
            chk("hblank", hblank, e.hb);
            chk("vblank", vblank, e.vb);
            if (e.det && e.x == 10 && e.y == 6) chk("px_10_6", screen_rgb_out, 24'h090909);
         end
      end
      if (ncx == 0 && ncy == 0) begin
         frame++;
         det_frame = (frame == 0);
         for (int i = 0; i < FW * FH; i++)
            fb_mem[i] = det_frame ? PB'(i) : PB'($urandom);
         for (int i = 0; i < 256; i++)
            pal[i] = det_frame ? {8'(i), 8'(i), 8'(i)} : RB'($urandom);
      end
      cx = 12'(ncx);
      cy = 12'(ncy);
      q.push_back(model(ncx, ncy));
      prev_valid = 1'b1;
      pcx = ncx;
      pcy = ncy;
      ncx++;
      if (ncx == htot) begin
         ncx = 0;
         ncy = (ncy + 1) % vtot;
      end
   endtask

   task automatic chk_reset(string tag);
      chk({tag, "_rgb"}, screen_rgb_out, 0);
      chk({tag, "_fb_rd"}, fb_rd, 0);
      chk({tag, "_fb_addr"}, fb_addr, 0);
      chk({tag, "_pal_addr"}, palette_addr, 0);
      chk({tag, "_hblank"}, hblank, 1);
      chk({tag, "_vblank"}, vblank, 1);
      chk({tag, "_underrun"}, underrun, 0);
   endtask

   task automatic do_reset(string tag);
      rst = 1'b1;
      cx = '0;
      cy = '0;
      ncx = 0;
      ncy = 0;
      q.delete();
      prev_valid = 1'b0;
      ur_exp = 1'b0;
      frame = -1;
      repeat (2) @(posedge clk);
      #1;
      chk_reset(tag);
      rst = 1'b0;
   endtask

   initial begin
      bit found;
      sw = 12'(SW);
      sh = 12'(SH);
      htot = 40;
      vtot = 20;
      pix_chk = 1'b1;
      det_frame = 1'b1;
      for (int i = 0; i < FW * FH; i++) fb_mem[i] = '0;
      for (int i = 0; i < 256; i++) pal[i] = '0;

      // Normal scanout: one deterministic frame, then two random frames
      do_reset("rst0");
      repeat (3 * htot * vtot) step();

      // Screen line too short for a row fetch
      htot = 9;
      pix_chk = 1'b0;
      do_reset("rst1");
      repeat (htot * 12) step();
      chk("underrun_sticky", underrun, 1);
      do_reset("rst2");

      // Reset in the middle of a row fetch
      htot = 40;
      pix_chk = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         step();
         if (fb_rd === 1'b1 && fb_addr == AB'(5)) found = 1'b1;
      end
      chk("wait_fetch_addr5", found, 1);
      rst = 1'b1;
      #1;
      chk_reset("rst_mid");
      @(posedge clk);
      #1;
      chk("rst_mid_fb_rd_edge", fb_rd, 0);

      // Recovery after aborted fetch
      do_reset("rst3");
      repeat (htot * vtot) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
